fadd_arbiter: RTL

Round-robin arbiter and sequencer that shares one `FloatAdder` instance among `NREQ` requesters. It accepts one operand pair at a time and drives the adder's `InputValid` for exactly one cycle. It waits for the adder's `ResultValid`, then returns the sum to the granted requester with a one-cycle `Done` pulse. A watchdog counter aborts hung operations, reports an error and pulses a reset into the adder.

---
 rtl/fadd_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - round-robin arbiter and sequencer sharing one FloatAdder among NREQ requesters
// One operation in flight at a time; a watchdog aborts hung adds and resets the adder.
module fadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Req,
    input  logic [32*NREQ-1:0]   ReqOp1,
    input  logic [32*NREQ-1:0]   ReqOp2,
    output logic [NREQ-1:0]      Grant,
    output logic [NREQ-1:0]      Done,
    output logic [31:0]          Result,
    output logic                 Error,
    output logic                 Busy,
    output logic [31:0]          AddOp1,
    output logic [31:0]          AddOp2,
    output logic                 AddInputValid,
    output logic                 AddReset,
    input  logic [31:0]          AddResult,
    input  logic                 AddResultValid
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]     add_op1_q, add_op1_d;
    logic [31:0]     add_op2_q, add_op2_d;
    logic [31:0]     result_q, result_d;
    logic            error_q, error_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            add_valid_q, add_valid_d;
    logic            abort_q, abort_d;

    logic [31:0]     op1_arr [NREQ];
    logic [31:0]     op2_arr [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op1_arr[g] = ReqOp1[32*g +: 32];
        assign op2_arr[g] = ReqOp2[32*g +: 32];
    end

    // Search starts just after the last winner so every pending requester is served in turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant_q) + k) % NREQ);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        add_op1_d    = add_op1_q;
        add_op2_d    = add_op2_q;
        result_d     = result_q;
        error_d      = error_q;
        grant_d      = '0;
        done_d       = '0;
        add_valid_d  = 1'b0;
        abort_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    add_op1_d    = op1_arr[win_idx];
                    add_op2_d    = op2_arr[win_idx];
                    owner_d      = win_idx;
                    last_grant_d = win_idx;
                    grant_d      = NREQ'(1) << win_idx;
                    add_valid_d  = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                // The first WAIT cycle is blanked: a valid there may belong to the previous add.
                if (wait_cnt_q != '0 && AddResultValid) begin
                    result_d = AddResult;
                    error_d  = 1'b0;
                    done_d   = NREQ'(1) << owner_q;
                    state_d  = S_IDLE;
                end else if (wait_cnt_q == CNT_MAX) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    done_d   = NREQ'(1) << owner_q;
                    abort_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            wait_cnt_q   <= '0;
            add_op1_q    <= '0;
            add_op2_q    <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            add_valid_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            add_op1_q    <= add_op1_d;
            add_op2_q    <= add_op2_d;
            result_q     <= result_d;
            error_q      <= error_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            add_valid_q  <= add_valid_d;
            abort_q      <= abort_d;
        end
    end

    assign Grant         = grant_q;
    assign Done          = done_q;
    assign Result        = result_q;
    assign Error         = error_q;
    assign Busy          = (state_q != S_IDLE);
    assign AddOp1        = add_op1_q;
    assign AddOp2        = add_op2_q;
    assign AddInputValid = add_valid_q;
    assign AddReset      = Reset | abort_q;

endmodule
